// File: rtl/eco_pkg.sv
// Shared types and sizing for the ECO miter sweep: FSM state encoding and
// vector/counter widths.
package eco_pkg;

  localparam int NUM_VEC = 8;
  localparam int VEC_W   = 3;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/eco_golden.sv
// Golden reference for the ECO miter: pure combinational model of the
// intended y1/y2 functions of inputs a, b, c.
module eco_golden (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y1,
  output logic y2
);

  assign y1 = (a & b) & (a ^ c);
  assign y2 = (a & b) | (a ^ c) | ~(b | c);

endmodule

// File: rtl/eco_miter_sweep.sv
// Exhaustive 3-input sweep comparing an implementation against eco_golden.
// Optional macro ECO_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module eco_miter_sweep
  import eco_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             c,
  input  logic             impl_y1,
  input  logic             impl_y2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [VEC_W-1:0] first_fail_vec,
  output logic             first_fail_valid
);

  localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);
  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);
  // With no settle time a new vector is checked in the very cycle it appears.
  localparam state_e VEC_ENTRY = (SETTLE == 0) ? CHECK : DRIVE;

  state_e           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [VEC_W-1:0] first_vec_q, first_vec_d;
  logic             first_valid_q, first_valid_d;
  logic             pass_q, pass_d;

  logic             gold_y1, gold_y2;
  logic             mismatch;
  logic             last_check;

  eco_golden u_golden (
    .a  (vec_q[2]),
    .b  (vec_q[1]),
    .c  (vec_q[0]),
    .y1 (gold_y1),
    .y2 (gold_y2)
  );

  assign mismatch = ({impl_y1, impl_y2} != {gold_y1, gold_y2});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      vec_q         <= '0;
      wait_q        <= '0;
      fail_cnt_q    <= '0;
      first_vec_q   <= '0;
      first_valid_q <= 1'b0;
      pass_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      vec_q         <= vec_d;
      wait_q        <= wait_d;
      fail_cnt_q    <= fail_cnt_d;
      first_vec_q   <= first_vec_d;
      first_valid_q <= first_valid_d;
      pass_q        <= pass_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    vec_d         = vec_q;
    wait_d        = wait_q;
    fail_cnt_d    = fail_cnt_q;
    first_vec_d   = first_vec_q;
    first_valid_d = first_valid_q;
    pass_d        = pass_q;
    last_check    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = VEC_ENTRY;
          vec_d         = '0;
          wait_d        = SETTLE_C;
          fail_cnt_d    = '0;
          first_vec_d   = '0;
          first_valid_d = 1'b0;
          pass_d        = 1'b0;
        end
      end

      DRIVE: begin
        wait_d = wait_q - 1'b1;
        if (wait_q <= CNT_W'(1)) begin
          state_d = CHECK;
        end
      end

      CHECK: begin
        if (mismatch) begin
          fail_cnt_d = fail_cnt_q + 1'b1;
          if (!first_valid_q) begin
            first_valid_d = 1'b1;
            first_vec_d   = vec_q;
          end
        end
`ifdef ECO_STOP_ON_FAIL_EN
        last_check = (vec_q == LAST_VEC) || mismatch;
`else
        last_check = (vec_q == LAST_VEC);
`endif
        // pass is decided on the way into DONE so it already covers this vector.
        if (last_check) begin
          state_d = DONE;
          pass_d  = (fail_cnt_d == '0);
        end else begin
          state_d = VEC_ENTRY;
          vec_d   = vec_q + 1'b1;
          wait_d  = SETTLE_C;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
    if ((state_q == DRIVE) || (state_q == CHECK)) begin
      {a, b, c} = vec_q;
    end else begin
      {a, b, c} = '0;
    end
  end

  assign pass             = pass_q;
  assign fail_cnt         = fail_cnt_q;
  assign first_fail_vec   = first_vec_q;
  assign first_fail_valid = first_valid_q;

endmodule

// File: tb/tb_eco_miter_sweep.sv
// Directed self-checking bench for eco_miter_sweep (SETTLE=1 and SETTLE=0
// instances); the implementation under check is modelled with injectable faults.
module tb_eco_miter_sweep;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       start1;
  logic       invY1;
  logic       stuckY2;

  logic       a0, b0, c0, busy0, done0, pass0, ffValid0;
  logic [3:0] failCnt0;
  logic [2:0] ffVec0;
  logic       implY1_0, implY2_0;
  logic [1:0] ref0;

  logic       a1, b1, c1, busy1, done1, pass1, ffValid1;
  logic [3:0] failCnt1;
  logic [2:0] ffVec1;
  logic       implY1_1, implY2_1;
  logic [1:0] ref1;

  int passCount  = 0;
  int failCount  = 0;
  int totalCount = 0;

`ifdef ECO_STOP_ON_FAIL_EN
  localparam int EXP_Y2_CYCLES = 6;
  localparam int EXP_Y2_FAILS  = 1;
  localparam int EXP_Y1_CYCLES = 2;
  localparam int EXP_Y1_FAILS  = 1;
`else
  localparam int EXP_Y2_CYCLES = 16;
  localparam int EXP_Y2_FAILS  = 2;
  localparam int EXP_Y1_CYCLES = 16;
  localparam int EXP_Y1_FAILS  = 8;
`endif

  function automatic logic [1:0] goldRef(input logic [2:0] v);
    case (v)
      3'd0: goldRef = 2'b01;
      3'd1: goldRef = 2'b01;
      3'd2: goldRef = 2'b00;
      3'd3: goldRef = 2'b01;
      3'd4: goldRef = 2'b01;
      3'd5: goldRef = 2'b00;
      3'd6: goldRef = 2'b11;
      default: goldRef = 2'b01;
    endcase
  endfunction

  assign ref0     = goldRef({a0, b0, c0});
  assign implY1_0 = ref0[1] ^ invY1;
  assign implY2_0 = ref0[0] | stuckY2;
  assign ref1     = goldRef({a1, b1, c1});
  assign implY1_1 = ref1[1];
  assign implY2_1 = ref1[0];

  eco_miter_sweep #(.SETTLE(1)) dut0 (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .a                (a0),
    .b                (b0),
    .c                (c0),
    .impl_y1          (implY1_0),
    .impl_y2          (implY2_0),
    .busy             (busy0),
    .done             (done0),
    .pass             (pass0),
    .fail_cnt         (failCnt0),
    .first_fail_vec   (ffVec0),
    .first_fail_valid (ffValid0)
  );

  eco_miter_sweep #(.SETTLE(0)) dut1 (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start1),
    .a                (a1),
    .b                (b1),
    .c                (c1),
    .impl_y1          (implY1_1),
    .impl_y2          (implY2_1),
    .busy             (busy1),
    .done             (done1),
    .pass             (pass1),
    .fail_cnt         (failCnt1),
    .first_fail_vec   (ffVec1),
    .first_fail_valid (ffValid1)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic iy1, input logic sy2);
    start   = s;
    invY1   = iy1;
    stuckY2 = sy2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start on dut0 and count edges from the start-sampling edge to done.
  task automatic runSweep(output int n);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (done0 !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int         n;
    int         m;
    logic [2:0] abcAt4;
    logic       doneSeen;
    logic       seqOk;

    rst_n = 1'b0;
    start1 = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", busy0, 1'b0);
    checkOutput("reset_done", done0, 1'b0);
    checkOutput("reset_pass", pass0, 1'b0);
    checkOutput("reset_fail_cnt", failCnt0, 4'd0);
    checkOutput("reset_ff_valid", ffValid0, 1'b0);
    checkOutput("reset_abc", {a0, b0, c0}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("[TB] clean sweep with a start pulse injected during DRIVE");
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    start = 1'b0;
    checkOutput("clean_busy_after_start", busy0, 1'b1);
    n = 0;
    abcAt4 = 3'bxxx;
    while (done0 !== 1'b1 && n < 60) begin
      tick();
      n++;
      if (n == 2) start = 1'b1;
      if (n == 3) start = 1'b0;
      if (n == 4) abcAt4 = {a0, b0, c0};
    end
    checkOutput("clean_cycles", n, 16);
    checkOutput("clean_pass", pass0, 1'b1);
    checkOutput("clean_fail_cnt", failCnt0, 4'd0);
    checkOutput("clean_ff_valid", ffValid0, 1'b0);
    checkOutput("clean_abc_vec2", abcAt4, 3'b010);
    checkOutput("clean_busy_in_done", busy0, 1'b1);
    checkOutput("clean_abc_in_done", {a0, b0, c0}, 3'b000);
    tick();
    checkOutput("clean_done_pulse_ends", done0, 1'b0);
    checkOutput("clean_idle_busy", busy0, 1'b0);
    checkOutput("clean_pass_held", pass0, 1'b1);

    $display("[TB] impl_y2 stuck at 1");
    applyStimulus(1'b0, 1'b0, 1'b1);
    runSweep(n);
    checkOutput("y2stuck_cycles", n, EXP_Y2_CYCLES);
    checkOutput("y2stuck_fail_cnt", failCnt0, EXP_Y2_FAILS);
    checkOutput("y2stuck_ff_valid", ffValid0, 1'b1);
    checkOutput("y2stuck_ff_vec", ffVec0, 3'b010);
    checkOutput("y2stuck_pass", pass0, 1'b0);
    tick();

    $display("[TB] impl_y1 inverted");
    applyStimulus(1'b0, 1'b1, 1'b0);
    runSweep(n);
    checkOutput("y1inv_cycles", n, EXP_Y1_CYCLES);
    checkOutput("y1inv_fail_cnt", failCnt0, EXP_Y1_FAILS);
    checkOutput("y1inv_ff_vec", ffVec0, 3'b000);
    checkOutput("y1inv_pass", pass0, 1'b0);
    tick();

    $display("[TB] start held high across back-to-back sweeps");
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("restart_clears_fail_cnt", failCnt0, 4'd0);
    checkOutput("restart_clears_ff_valid", ffValid0, 1'b0);
    checkOutput("restart_busy", busy0, 1'b1);
    n = 0;
    while (done0 !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    checkOutput("held_cycles", n, 16);
    checkOutput("held_pass", pass0, 1'b1);
    tick();
    checkOutput("held_idle_gap", busy0, 1'b0);
    tick();
    checkOutput("held_restart_busy", busy0, 1'b1);
    checkOutput("held_restart_abc", {a0, b0, c0}, 3'b000);
    start = 1'b0;

    $display("[TB] reset asserted at vector 4");
    m = 0;
    while ({a0, b0, c0} !== 3'b100 && m < 40) begin
      tick();
      m++;
    end
    checkOutput("reach_vec4_cycles", m, 8);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_busy", busy0, 1'b0);
    checkOutput("midreset_abc", {a0, b0, c0}, 3'b000);
    checkOutput("midreset_done", done0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    doneSeen = 1'b0;
    repeat (20) begin
      tick();
      doneSeen = doneSeen | done0;
    end
    checkOutput("midreset_no_done", doneSeen, 1'b0);
    checkOutput("midreset_stays_idle", busy0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("post_reset_vec0", {a0, b0, c0}, 3'b000);
    tick();
    tick();
    checkOutput("post_reset_vec1", {a0, b0, c0}, 3'b001);
    n = 2;
    while (done0 !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    checkOutput("post_reset_cycles", n, 16);
    checkOutput("post_reset_pass", pass0, 1'b1);

    $display("[TB] SETTLE=0 instance");
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n = 0;
    seqOk = 1'b1;
    while (done1 !== 1'b1 && n < 40) begin
      if (n < 8 && {a1, b1, c1} !== n[2:0]) seqOk = 1'b0;
      tick();
      n++;
    end
    checkOutput("settle0_vector_sequence", seqOk, 1'b1);
    checkOutput("settle0_cycles", n, 8);
    checkOutput("settle0_pass", pass1, 1'b1);
    checkOutput("settle0_fail_cnt", failCnt1, 4'd0);
    checkOutput("settle0_ff_valid", ffValid1, 1'b0);
    tick();
    checkOutput("settle0_idle", busy1, 1'b0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
